// File: rtl/tick_gen_pkg.sv
// rtl/tick_gen_pkg.sv - shared constants and types for the multi-channel tick generator
package tick_gen_pkg;

   localparam int CNT_W_DEF = 27;

   typedef logic [CNT_W_DEF-1:0] cnt_t;

   // Divisors for a 100 MHz system clock; period = D+1 cycles
   localparam int unsigned DIV_100HZ = 32'd999_999;
   localparam int unsigned DIV_1HZ   = 32'd99_999_999;
   localparam int unsigned DIV_2HZ   = 32'd49_999_999;

   // One extra select bit so that out-of-range channel numbers can be presented and rejected
   function automatic int sel_width(input int num_ch);
      return $clog2(num_ch + 1);
   endfunction

endpackage

// File: rtl/tick_gen_multi_if.sv
// rtl/tick_gen_multi_if.sv - control/divisor-write inputs and tick/square outputs of tick_gen_multi
interface tick_gen_multi_if
   import tick_gen_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = CNT_W_DEF
);
   localparam int SEL_W = sel_width(NUM_CH);

   logic              en;
   logic              clr;
   logic              div_wr;
   logic [SEL_W-1:0]  div_sel;
   logic [CNT_W-1:0]  div_val;
   logic [NUM_CH-1:0] tick;
   logic [NUM_CH-1:0] sq;

   modport master (
      output en, clr, div_wr, div_sel, div_val,
      input  tick, sq
   );

   modport slave (
      input  en, clr, div_wr, div_sel, div_val,
      output tick, sq
   );

endinterface

// File: rtl/tick_chan.sv
// rtl/tick_chan.sv - one timebase channel: counter, shadow/active divisor, tick flop, optional sq flop
// Square-wave flop present only when TICK_GEN_SQUARE_EN is defined.
module tick_chan #(
   parameter int               CNT_W   = 27,
   parameter logic [CNT_W-1:0] RST_DIV = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en_i,
   input  logic             clr_i,
   input  logic             wr_i,
   input  logic [CNT_W-1:0] wr_val_i,
   output logic             tick_o,
   output logic             sq_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] shadow_q, shadow_d;
   logic [CNT_W-1:0] active_q, active_d;
   logic             tick_q, tick_d;
   logic             wrap;

   assign wrap = !clr_i && en_i && (cnt_q == active_q);

   // shadow_d already carries a same-cycle write, giving write-through on wrap and clr
   always_comb begin
      shadow_d = wr_i ? wr_val_i : shadow_q;
      cnt_d    = cnt_q;
      active_d = active_q;
      tick_d   = 1'b0;
      if (clr_i) begin
         cnt_d    = '0;
         active_d = shadow_d;
      end else if (wrap) begin
         cnt_d    = '0;
         active_d = shadow_d;
         tick_d   = 1'b1;
      end else if (en_i) begin
         cnt_d    = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= '0;
         shadow_q <= RST_DIV;
         active_q <= RST_DIV;
         tick_q   <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         shadow_q <= shadow_d;
         active_q <= active_d;
         tick_q   <= tick_d;
      end
   end

   assign tick_o = tick_q;

`ifdef TICK_GEN_SQUARE_EN
   logic sq_q, sq_d;

   always_comb begin
      sq_d = sq_q;
      if (clr_i) begin
         sq_d = 1'b0;
      end else if (wrap) begin
         sq_d = ~sq_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sq_q <= 1'b0;
      end else begin
         sq_q <= sq_d;
      end
   end

   assign sq_o = sq_q;
`else
   assign sq_o = 1'b0;
`endif

endmodule

// File: rtl/tick_gen_multi.sv
// rtl/tick_gen_multi.sv - NUM_CH runtime-programmable tick-enable generators with pause/restart
// Optional square-wave outputs enabled by TICK_GEN_SQUARE_EN.
module tick_gen_multi
   import tick_gen_pkg::*;
#(
   parameter int          NUM_CH  = 4,
   parameter int          CNT_W   = CNT_W_DEF,
   parameter int unsigned DEF_DIV = DIV_100HZ
) (
   input  logic            clk,
   input  logic            reset,
   tick_gen_multi_if.slave bus
);

   localparam int SEL_W = sel_width(NUM_CH);

   if (NUM_CH < 1 || (64'(DEF_DIV) >> CNT_W) != 64'd0) begin : g_bad_cfg
      $error("tick_gen_multi: NUM_CH must be >= 1 and DEF_DIV must fit in CNT_W bits");
   end

   logic [NUM_CH-1:0] wr_w;
   logic [NUM_CH-1:0] tick_w;
   logic [NUM_CH-1:0] sq_w;

   // Selects at or above NUM_CH match no channel, so such writes are dropped
   for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
      assign wr_w[i] = bus.div_wr && (bus.div_sel == SEL_W'(i));

      tick_chan #(
         .CNT_W   (CNT_W),
         .RST_DIV (CNT_W'(DEF_DIV))
      ) u_chan (
         .clk      (clk),
         .rst_n    (reset),
         .en_i     (bus.en),
         .clr_i    (bus.clr),
         .wr_i     (wr_w[i]),
         .wr_val_i (bus.div_val),
         .tick_o   (tick_w[i]),
         .sq_o     (sq_w[i])
      );
   end

   assign bus.tick = tick_w;
   assign bus.sq   = sq_w;

endmodule

// File: tb/tb_tick_gen_multi.sv
// tb/tb_tick_gen_multi.sv - self-checking bench for tick_gen_multi (NUM_CH=4, DEF_DIV=9)
module tb_tick_gen_multi;

   localparam int NCH  = 4;
   localparam int CW   = 27;
   localparam int DDIV = 9;
`ifdef TICK_GEN_SQUARE_EN
   localparam bit SQ_ON = 1'b1;
`else
   localparam bit SQ_ON = 1'b0;
`endif

   logic clk;
   logic rst_n;
   int   vectors;
   int   miscompares;

   tick_gen_multi_if #(.NUM_CH(NCH), .CNT_W(CW)) bus ();

   tick_gen_multi #(.NUM_CH(NCH), .CNT_W(CW), .DEF_DIV(DDIV)) dut (
      .clk   (clk),
      .reset (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: each channel counts enabled edges since its last tick; period is div+1
   int         m_elapsed [NCH];
   int         m_div     [NCH];
   int         m_shadow  [NCH];
   logic [3:0] m_tick;
   logic [3:0] m_sq;

   task automatic model_reset();
      for (int c = 0; c < NCH; c++) begin
         m_elapsed[c] = 0;
         m_div[c]     = DDIV;
         m_shadow[c]  = DDIV;
      end
      m_tick = '0;
      m_sq   = '0;
   endtask

   task automatic model_edge(input logic en_v, input logic clr_v, input logic wr_v,
                             input logic [2:0] sel_v, input logic [26:0] val_v);
      for (int c = 0; c < NCH; c++) begin
         int next_shadow;
         next_shadow = (wr_v && int'(sel_v) == c) ? int'(val_v) : m_shadow[c];
         m_tick[c] = 1'b0;
         if (clr_v) begin
            m_elapsed[c] = 0;
            m_sq[c]      = 1'b0;
            m_div[c]     = next_shadow;
         end else if (en_v) begin
            if (m_elapsed[c] + 1 == m_div[c] + 1) begin
               m_tick[c]    = 1'b1;
               m_sq[c]      = ~m_sq[c];
               m_elapsed[c] = 0;
               m_div[c]     = next_shadow;
            end else begin
               m_elapsed[c] = m_elapsed[c] + 1;
            end
         end
         m_shadow[c] = next_shadow;
      end
   endtask

   task automatic check_model(input string tag);
      logic [3:0] exp_sq;
      exp_sq = SQ_ON ? m_sq : 4'h0;
      vectors++;
      if (bus.tick !== m_tick || bus.sq !== exp_sq) begin
         miscompares++;
         $display("FAIL %s t=%0t: tick=%h sq=%h, expected tick=%h sq=%h",
                  tag, $time, bus.tick, bus.sq, m_tick, exp_sq);
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s t=%0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      if (rst_n) model_edge(bus.en, bus.clr, bus.div_wr, bus.div_sel, bus.div_val);
      else       model_reset();
      #1;
      check_model("model");
   endtask

   task automatic cyc(input logic en_v, input logic clr_v, input logic wr_v,
                      input logic [2:0] sel_v, input logic [26:0] val_v);
      bus.en      = en_v;
      bus.clr     = clr_v;
      bus.div_wr  = wr_v;
      bus.div_sel = sel_v;
      bus.div_val = val_v;
      step();
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cyc(1'b1, 1'b0, 1'b0, 3'd0, 27'd0);
   endtask

   typedef struct {
      logic        en;
      logic        clr;
      logic        wr;
      logic [2:0]  sel;
      logic [26:0] val;
      logic [3:0]  exp_tick;
      logic [3:0]  exp_sq;
   } vec_t;

   vec_t tbl [30];

   initial begin
      #200_000;
      $display("FAIL watchdog: simulation did not finish, expected end before 200000");
      $fatal(1);
   end

   initial begin
      vectors     = 0;
      miscompares = 0;

      // Release from reset: ticks at edges 10, 20, 30; invalid-channel writes must be no-ops
      for (int i = 0; i < 30; i++) begin
         tbl[i] = '{en: 1'b1, clr: 1'b0, wr: (i == 3 || i == 14), sel: 3'd4, val: 27'd0,
                    exp_tick: ((i + 1) % 10 == 0) ? 4'hF : 4'h0,
                    exp_sq:   (((i + 1) / 10) % 2 == 1) ? 4'hF : 4'h0};
      end

      rst_n       = 1'b0;
      bus.en      = 1'b1;
      bus.clr     = 1'b0;
      bus.div_wr  = 1'b0;
      bus.div_sel = '0;
      bus.div_val = '0;
      model_reset();

      for (int k = 0; k < 10; k++) begin
         step();
         chk("reset_tick", 32'(bus.tick), 32'h0);
      end
      chk("reset_sq", 32'(bus.sq), 32'h0);
      rst_n = 1'b1;

      foreach (tbl[i]) begin
         cyc(tbl[i].en, tbl[i].clr, tbl[i].wr, tbl[i].sel, tbl[i].val);
         chk("tbl_tick", 32'(bus.tick), 32'(tbl[i].exp_tick));
         chk("tbl_sq",   32'(bus.sq),   SQ_ON ? 32'(tbl[i].exp_sq) : 32'h0);
      end

      // Mid-count write ch1 D=3 at cnt=4: finishes current period at edge 40, then every 4
      idle(4);
      cyc(1'b1, 1'b0, 1'b1, 3'd1, 27'd3);
      idle(5);
      chk("midwr_e40", 32'(bus.tick), 32'hF);
      idle(4);
      chk("midwr_e44", 32'(bus.tick), 32'h2);
      idle(4);
      chk("midwr_e48", 32'(bus.tick), 32'h2);
      idle(2);
      chk("midwr_e50", 32'(bus.tick), 32'hD);

      // Pause five cycles at cnt=6: ch0/2/3 tick at edge 65 instead of 60
      idle(6);
      for (int k = 0; k < 5; k++) begin
         cyc(1'b0, 1'b0, 1'b0, 3'd0, 27'd0);
         chk("pause_tick", 32'(bus.tick), 32'h0);
      end
      chk("pause_sq", 32'(bus.sq), SQ_ON ? 32'hD : 32'h0);
      idle(3);
      chk("resume_e64", 32'(bus.tick & 4'hD), 32'h0);
      idle(1);
      chk("resume_e65", 32'(bus.tick & 4'hD), 32'hD);

      // clr with write-through ch2 D=0
      cyc(1'b1, 1'b1, 1'b1, 3'd2, 27'd0);
      chk("clr_tick", 32'(bus.tick), 32'h0);
      chk("clr_sq",   32'(bus.sq),   32'h0);
      idle(1);
      chk("clr_p1", 32'(bus.tick), 32'h4);
      idle(9);
      chk("clr_p10", 32'(bus.tick), 32'hD);

      // Asynchronous reset between edges
      #3;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_model("async_rst");
      chk("async_tick", 32'(bus.tick), 32'h0);
      chk("async_sq",   32'(bus.sq),   32'h0);
      step();
      step();
      rst_n = 1'b1;
      idle(4);
      chk("rel_e4", 32'(bus.tick), 32'h0);
      idle(6);
      chk("rel_e10", 32'(bus.tick), 32'hF);

      // Randomised traffic against the reference model
      for (int i = 0; i < 1500; i++) begin
         logic        r_en, r_clr, r_wr;
         logic [2:0]  r_sel;
         logic [26:0] r_val;
         r_en  = ($urandom % 8) != 0;
         r_clr = ($urandom % 64) == 0;
         r_wr  = ($urandom % 6) == 0;
         r_sel = 3'($urandom % 6);
         r_val = 27'($urandom % 13);
         cyc(r_en, r_clr, r_wr, r_sel, r_val);
         if (($urandom % 300) == 0) begin
            #2;
            rst_n = 1'b0;
            #1;
            model_reset();
            check_model("rand_async_rst");
            step();
            rst_n = 1'b1;
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
